mb_reconstruct_writer: RTL

//  Reads one macroblock of motion-compensated prediction samples (8-bit, by address) and the matching

---
 rtl/mb_reconstruct_writer_pkg.sv | 22 ++
 rtl/mb_reconstruct_writer_if.sv | 24 ++
 rtl/mb_reconstruct_writer_recon_pixel_sat.sv | 19 +
 rtl/mb_reconstruct_writer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mb_reconstruct_writer_pkg.sv
// Shared state codes, sample-index landmarks and default plane bases for the
// macroblock reconstruction writer.
package mb_reconstruct_writer_pkg;

  typedef enum logic [1:0] {
    MB_RECON_IDLE  = 2'd0,
    MB_RECON_READ  = 2'd1,
    MB_RECON_WRITE = 2'd2
  } recon_state_e;

  localparam logic [18:0] CB_BASE_DEFAULT = 19'h19500;
  localparam logic [18:0] CR_BASE_DEFAULT = 19'h1FA40;

  localparam int unsigned RECON_CB_FIRST_IDX = 256;
  localparam int unsigned RECON_CR_FIRST_IDX = 320;
  localparam int unsigned RECON_LAST_WORD    = 95;

  // Last word of the Y and Cb planes; the following word starts a new plane origin.
  localparam logic [6:0] RECON_Y_LAST_WORD  = 7'(RECON_CB_FIRST_IDX / 4 - 1);
  localparam logic [6:0] RECON_CB_LAST_WORD = 7'(RECON_CR_FIRST_IDX / 4 - 1);

endpackage

// File: rtl/mb_reconstruct_writer_if.sv
// Sample read ports (prediction + residual) and framestore write port.
interface mb_reconstruct_writer_if;
  logic [10:0] Prediction_Address_O;
  logic [7:0]  Prediction_Data_I;
  logic [8:0]  Residual_Address_O;
  logic [8:0]  Residual_Data_I;
  logic [18:0] Framestore_Address_O;
  logic [31:0] Framestore_Data_O;
  logic        Framestore_Write_En_O;
  logic        Framestore_Busy_I;
  logic        Framestore_Active_O;

  modport master (
    output Prediction_Address_O, Residual_Address_O,
           Framestore_Address_O, Framestore_Data_O, Framestore_Write_En_O, Framestore_Active_O,
    input  Prediction_Data_I, Residual_Data_I, Framestore_Busy_I
  );

  modport slave (
    input  Prediction_Address_O, Residual_Address_O,
           Framestore_Address_O, Framestore_Data_O, Framestore_Write_En_O, Framestore_Active_O,
    output Prediction_Data_I, Residual_Data_I, Framestore_Busy_I
  );
endinterface

// File: rtl/mb_reconstruct_writer_recon_pixel_sat.sv
// Prediction + signed residual, clamped to an 8-bit pixel.
module recon_pixel_sat (
  input  logic [7:0] pred_i,
  input  logic [8:0] res_i,
  input  logic       intra_i,
  output logic [7:0] pix_o
);
  logic [7:0]        pred_eff;
  logic signed [9:0] sum;

  assign pred_eff = intra_i ? 8'd0 : pred_i;
  assign sum      = $signed({2'b00, pred_eff}) + $signed({res_i[8], res_i});

  always_comb begin
    pix_o = sum[7:0];
    if (sum < 10'sd0)        pix_o = 8'd0;
    else if (sum > 10'sd255) pix_o = 8'd255;
  end
endmodule

// File: rtl/mb_reconstruct_writer.sv
// Reconstructs one 4:2:0 macroblock: reads 4 samples per word, adds and saturates,
// packs them and writes 96 words into the framestore using per-plane line accumulators.
module mb_reconstruct_writer
  import mb_reconstruct_writer_pkg::*;
#(
  parameter logic [18:0] CB_BASE_ADDR = CB_BASE_DEFAULT,
  parameter logic [18:0] CR_BASE_ADDR = CR_BASE_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        Start_Recon_I,
  output logic        Done_Recon_O,
  input  logic [8:0]  Current_MB_Row_I,
  input  logic [9:0]  Current_MB_Column_I,
  input  logic [11:0] Image_Horizontal_I,
  input  logic        Macroblock_Intra_I,
  mb_reconstruct_writer_if.master bus
);
  recon_state_e state_q;
  logic [2:0]   rcnt_q;
  logic [8:0]   idx_q;
  logic [1:0]   xw_q, xw_d;
  logic [18:0]  line_q, line_d, cb_org_q, cr_org_q, ystr_q, cstr_q, fs_addr_q;
  logic [31:0]  pack_q;
  logic         we_q, done_q, active_q, intra_q;
  logic [6:0]   word;
  logic [7:0]   pix;
  logic [18:0]  row19, col19, w19, y_org_c, cb_off_c;

  assign row19    = 19'(Current_MB_Row_I);
  assign col19    = 19'(Current_MB_Column_I);
  assign w19      = 19'(Image_Horizontal_I);
  // Plane origins are the only multiplies; they run once at start.
  assign y_org_c  = (row19 * 19'd16) * (w19 >> 2) + col19 * 19'd4;
  assign cb_off_c = (row19 * 19'd8) * (w19 >> 3) + col19 * 19'd2;

  // While in WRITE, idx_q sits at 4k+3 so its upper bits are the word number.
  assign word = idx_q[8:2];

  recon_pixel_sat u_sat (
    .pred_i  (bus.Prediction_Data_I),
    .res_i   (bus.Residual_Data_I),
    .intra_i (intra_q),
    .pix_o   (pix)
  );

  always_comb begin
    line_d = line_q;
    xw_d   = xw_q + 2'd1;
    if (word == RECON_Y_LAST_WORD) begin
      line_d = cb_org_q;
      xw_d   = 2'd0;
    end else if (word == RECON_CB_LAST_WORD) begin
      line_d = cr_org_q;
      xw_d   = 2'd0;
    end else if (word < RECON_Y_LAST_WORD) begin
      if (xw_q == 2'd3) begin
        line_d = line_q + ystr_q;
        xw_d   = 2'd0;
      end
    end else if (xw_q == 2'd1) begin
      line_d = line_q + cstr_q;
      xw_d   = 2'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= MB_RECON_IDLE;
      rcnt_q    <= '0;
      idx_q     <= '0;
      xw_q      <= '0;
      line_q    <= '0;
      cb_org_q  <= '0;
      cr_org_q  <= '0;
      ystr_q    <= '0;
      cstr_q    <= '0;
      fs_addr_q <= '0;
      pack_q    <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b1;
      active_q  <= 1'b0;
      intra_q   <= 1'b0;
    end else begin
      case (state_q)
        MB_RECON_IDLE: if (Start_Recon_I) begin
          state_q  <= MB_RECON_READ;
          done_q   <= 1'b0;
          active_q <= 1'b1;
          rcnt_q   <= '0;
          idx_q    <= '0;
          xw_q     <= '0;
          intra_q  <= Macroblock_Intra_I;
          line_q   <= y_org_c;
          cb_org_q <= CB_BASE_ADDR + cb_off_c;
          cr_org_q <= CR_BASE_ADDR + cb_off_c;
          ystr_q   <= w19 >> 2;
          cstr_q   <= w19 >> 3;
        end
        MB_RECON_READ: begin
          // Data arrives one cycle after its address, so slot n fills at rcnt n+1.
          case (rcnt_q)
            3'd1:    pack_q[31:24] <= pix;
            3'd2:    pack_q[23:16] <= pix;
            3'd3:    pack_q[15:8]  <= pix;
            3'd4:    pack_q[7:0]   <= pix;
            default: ;
          endcase
          if (rcnt_q < 3'd3) idx_q <= idx_q + 9'd1;
          if (rcnt_q == 3'd4) begin
            state_q   <= MB_RECON_WRITE;
            rcnt_q    <= '0;
            we_q      <= 1'b1;
            fs_addr_q <= line_q + 19'(xw_q);
          end else begin
            rcnt_q <= rcnt_q + 3'd1;
          end
        end
        MB_RECON_WRITE: if (!bus.Framestore_Busy_I) begin
          we_q   <= 1'b0;
          idx_q  <= idx_q + 9'd1;
          line_q <= line_d;
          xw_q   <= xw_d;
          if (word == 7'(RECON_LAST_WORD)) begin
            state_q  <= MB_RECON_IDLE;
            done_q   <= 1'b1;
            active_q <= 1'b0;
          end else begin
            state_q <= MB_RECON_READ;
          end
        end
        default: state_q <= MB_RECON_IDLE;
      endcase
    end
  end

  assign Done_Recon_O              = done_q;
  assign bus.Prediction_Address_O  = {2'b00, idx_q};
  assign bus.Residual_Address_O    = idx_q;
  assign bus.Framestore_Address_O  = fs_addr_q;
  assign bus.Framestore_Data_O     = pack_q;
  assign bus.Framestore_Write_En_O = we_q;
  assign bus.Framestore_Active_O   = active_q;
endmodule
